// File: rtl/nv_nvdla_pdp_layer_seq.sv
// PDP layer sequencer: tracks per-group op enables, gates RDMA beats through a
// one-stage output slice, and reports layer completion. Optional stall perf
// counter is built only when NVDLA_PDP_SEQ_PERF_EN is defined.
module nv_nvdla_pdp_layer_seq #(
    parameter int unsigned NVDLA_PDP_BWPE       = 8,
    parameter int unsigned NVDLA_PDP_THROUGHPUT = 8,
    localparam int unsigned PW = NVDLA_PDP_BWPE * NVDLA_PDP_THROUGHPUT + 12
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic [1:0]    reg2dp_op_en,
    input  logic [1:0]    reg2dp_flying_mode,
    input  logic          rdma2dp_valid,
    output logic          rdma2dp_ready,
    input  logic [PW-1:0] rdma2dp_pd,
    output logic          dp_pvld,
    input  logic          dp_prdy,
    output logic [PW-1:0] dp_pd,
    input  logic          wdma_done,
    output logic          dp2reg_done,
    output logic          dp2reg_consumer,
    output logic [31:0]   dp2reg_beat_num,
    output logic [31:0]   dp2reg_stall_num
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  op_en_d;
    logic [1:0]  pend;
    logic [1:0]  op_rise;
    logic [1:0]  pend_clr;
    logic        early_done;
    logic        accept;
    logic        layer_end;
    logic        go_done;
    logic [31:0] beat_cnt;

    // Ready depends only on state and slice occupancy, never on valid.
    assign rdma2dp_ready = (state == S_RUN) & (~dp_pvld | dp_prdy);
    assign accept        = rdma2dp_valid & rdma2dp_ready;
    assign layer_end     = accept & rdma2dp_pd[PW-1] & rdma2dp_pd[PW-5];
    assign go_done       = (state == S_WAIT) & (wdma_done | early_done);
    assign op_rise       = reg2dp_op_en & ~op_en_d;
    assign pend_clr      = {go_done & dp2reg_consumer, go_done & ~dp2reg_consumer};

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pend[dp2reg_consumer]) begin
                    state_nxt = reg2dp_flying_mode[dp2reg_consumer] ? S_RUN : S_WAIT;
                end
            end
            S_RUN: begin
                if (layer_end) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (go_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Layer bookkeeping; completion actions commit on entry to DONE so the
    // done pulse and the latched counts are visible in the same cycle.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            op_en_d         <= 2'b00;
            pend            <= 2'b00;
            early_done      <= 1'b0;
            dp2reg_done     <= 1'b0;
            dp2reg_consumer <= 1'b0;
            beat_cnt        <= 32'd0;
            dp2reg_beat_num <= 32'd0;
        end else begin
            op_en_d         <= reg2dp_op_en;
            pend            <= (pend | op_rise) & ~pend_clr;
            dp2reg_done     <= go_done;
            dp2reg_consumer <= dp2reg_consumer ^ go_done;
            if (go_done) begin
                early_done <= 1'b0;
            end else if ((state == S_RUN) && wdma_done) begin
                early_done <= 1'b1;
            end
            if (go_done) begin
                beat_cnt        <= 32'd0;
                dp2reg_beat_num <= beat_cnt;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end

    // Single-entry output slice.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dp_pvld <= 1'b0;
            dp_pd   <= '0;
        end else if (accept) begin
            dp_pvld <= 1'b1;
            dp_pd   <= rdma2dp_pd;
        end else if (dp_prdy) begin
            dp_pvld <= 1'b0;
        end
    end

`ifdef NVDLA_PDP_SEQ_PERF_EN
    logic [31:0] stall_cnt;
    logic        stall_inc;

    assign stall_inc = (state == S_RUN) & rdma2dp_valid & dp_pvld & ~dp_prdy;

    // Saturating count of RUN cycles where the slice back-pressures RDMA.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt        <= 32'd0;
            dp2reg_stall_num <= 32'd0;
        end else if (go_done) begin
            stall_cnt        <= 32'd0;
            dp2reg_stall_num <= stall_cnt;
        end else if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign dp2reg_stall_num = 32'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_pdp_layer_seq.sv
// Directed bench for nv_nvdla_pdp_layer_seq with hand-computed expectations.
module tb_nv_nvdla_pdp_layer_seq;

    localparam int unsigned PW = 8 * 8 + 12;

`ifdef NVDLA_PDP_SEQ_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic          nvdla_core_clk;
    logic          nvdla_core_rstn;
    logic [1:0]    reg2dp_op_en;
    logic [1:0]    reg2dp_flying_mode;
    logic          rdma2dp_valid;
    logic          rdma2dp_ready;
    logic [PW-1:0] rdma2dp_pd;
    logic          dp_pvld;
    logic          dp_prdy;
    logic [PW-1:0] dp_pd;
    logic          wdma_done;
    logic          dp2reg_done;
    logic          dp2reg_consumer;
    logic [31:0]   dp2reg_beat_num;
    logic [31:0]   dp2reg_stall_num;

    int checks = 0;
    int errors = 0;

    nv_nvdla_pdp_layer_seq #(
        .NVDLA_PDP_BWPE       (8),
        .NVDLA_PDP_THROUGHPUT (8)
    ) dut (
        .nvdla_core_clk     (nvdla_core_clk),
        .nvdla_core_rstn    (nvdla_core_rstn),
        .reg2dp_op_en       (reg2dp_op_en),
        .reg2dp_flying_mode (reg2dp_flying_mode),
        .rdma2dp_valid      (rdma2dp_valid),
        .rdma2dp_ready      (rdma2dp_ready),
        .rdma2dp_pd         (rdma2dp_pd),
        .dp_pvld            (dp_pvld),
        .dp_prdy            (dp_prdy),
        .dp_pd              (dp_pd),
        .wdma_done          (wdma_done),
        .dp2reg_done        (dp2reg_done),
        .dp2reg_consumer    (dp2reg_consumer),
        .dp2reg_beat_num    (dp2reg_beat_num),
        .dp2reg_stall_num   (dp2reg_stall_num)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    function automatic logic [PW-1:0] mk(input int unsigned idx, input logic ce, input logic se);
        logic [PW-1:0] p;
        p         = '0;
        p[31:0]   = 32'hA5C3_0000 + 32'(idx);
        p[47:32]  = 16'(idx * 16'h0101);
        p[PW-1]   = ce;
        p[PW-5]   = se;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge nvdla_core_clk);
        #2;
    endtask

    initial begin
        nvdla_core_rstn    = 1'b0;
        reg2dp_op_en       = 2'b00;
        reg2dp_flying_mode = 2'b01;
        rdma2dp_valid      = 1'b0;
        rdma2dp_pd         = '0;
        dp_prdy            = 1'b1;
        wdma_done          = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_pvld", 128'(dp_pvld), 128'(1'b0));
        chk("rst_pd", 128'(dp_pd), 128'(0));
        chk("rst_ready", 128'(rdma2dp_ready), 128'(1'b0));
        chk("rst_done", 128'(dp2reg_done), 128'(1'b0));
        chk("rst_consumer", 128'(dp2reg_consumer), 128'(1'b0));
        chk("rst_beat", 128'(dp2reg_beat_num), 128'(0));
        chk("rst_stall", 128'(dp2reg_stall_num), 128'(0));
        nvdla_core_rstn = 1'b1;
        tick();

        // wdma_done in IDLE is ignored
        wdma_done = 1'b1;
        tick();
        wdma_done = 1'b0;
        tick();
        chk("idle_wdma_done", 128'(dp2reg_done), 128'(1'b0));

        // Off-fly group 0, four beats
        reg2dp_op_en = 2'b01;
        tick();
        tick();
        chk("t1_ready_run", 128'(rdma2dp_ready), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            rdma2dp_valid = 1'b1;
            rdma2dp_pd    = mk(i, i == 3, i == 3);
            tick();
            chk($sformatf("t1_pvld%0d", i), 128'(dp_pvld), 128'(1'b1));
            chk($sformatf("t1_pd%0d", i), 128'(dp_pd), 128'(mk(i, i == 3, i == 3)));
        end
        rdma2dp_valid = 1'b0;
        rdma2dp_pd    = '0;
        chk("t1_ready_after_end", 128'(rdma2dp_ready), 128'(1'b0));
        tick();
        chk("t1_drain", 128'(dp_pvld), 128'(1'b0));
        chk("t1_no_early_done_a", 128'(dp2reg_done), 128'(1'b0));
        tick();
        chk("t1_no_early_done_b", 128'(dp2reg_done), 128'(1'b0));
        wdma_done = 1'b1;
        tick();
        wdma_done = 1'b0;
        chk("t1_done", 128'(dp2reg_done), 128'(1'b1));
        chk("t1_beat_num", 128'(dp2reg_beat_num), 128'(4));
        chk("t1_consumer", 128'(dp2reg_consumer), 128'(1'b1));
        tick();
        chk("t1_done_pulse", 128'(dp2reg_done), 128'(1'b0));

        // On-fly group 1: RDMA is never accepted
        reg2dp_op_en  = 2'b11;
        rdma2dp_valid = 1'b1;
        rdma2dp_pd    = mk(9, 1'b1, 1'b1);
        tick();
        tick();
        chk("t2_ready_a", 128'(rdma2dp_ready), 128'(1'b0));
        tick();
        chk("t2_ready_b", 128'(rdma2dp_ready), 128'(1'b0));
        chk("t2_pvld", 128'(dp_pvld), 128'(1'b0));
        chk("t2_no_done", 128'(dp2reg_done), 128'(1'b0));
        wdma_done = 1'b1;
        tick();
        wdma_done     = 1'b0;
        rdma2dp_valid = 1'b0;
        chk("t2_done", 128'(dp2reg_done), 128'(1'b1));
        chk("t2_consumer", 128'(dp2reg_consumer), 128'(1'b0));
        chk("t2_beat_num", 128'(dp2reg_beat_num), 128'(0));
        tick();
        chk("t2_done_pulse", 128'(dp2reg_done), 128'(1'b0));

        // Backpressure: dp_prdy low for five cycles mid-layer
        reg2dp_op_en = 2'b00;
        tick();
        reg2dp_op_en = 2'b01;
        tick();
        tick();
        rdma2dp_valid = 1'b1;
        rdma2dp_pd    = mk(20, 1'b0, 1'b0);
        tick();
        chk("t3_pd0", 128'(dp_pd), 128'(mk(20, 1'b0, 1'b0)));
        rdma2dp_pd = mk(21, 1'b0, 1'b0);
        tick();
        chk("t3_pd1", 128'(dp_pd), 128'(mk(21, 1'b0, 1'b0)));
        rdma2dp_pd = mk(22, 1'b0, 1'b0);
        dp_prdy    = 1'b0;
        #1;
        chk("t3_ready_bp", 128'(rdma2dp_ready), 128'(1'b0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t3_hold_pvld%0d", i), 128'(dp_pvld), 128'(1'b1));
            chk($sformatf("t3_hold_pd%0d", i), 128'(dp_pd), 128'(mk(21, 1'b0, 1'b0)));
        end
        dp_prdy = 1'b1;
        tick();
        chk("t3_pd2", 128'(dp_pd), 128'(mk(22, 1'b0, 1'b0)));
        rdma2dp_pd = mk(23, 1'b1, 1'b1);
        tick();
        chk("t3_pd3", 128'(dp_pd), 128'(mk(23, 1'b1, 1'b1)));
        rdma2dp_valid = 1'b0;
        wdma_done     = 1'b1;
        tick();
        wdma_done = 1'b0;
        chk("t3_done", 128'(dp2reg_done), 128'(1'b1));
        chk("t3_beat_num", 128'(dp2reg_beat_num), 128'(4));
        chk("t3_stall_num", 128'(dp2reg_stall_num), 128'(EXP_STALL));
        tick();

        // Early wdma_done during RUN, layer end two cycles later
        reg2dp_flying_mode = 2'b11;
        reg2dp_op_en       = 2'b11;
        tick();
        tick();
        rdma2dp_valid = 1'b1;
        rdma2dp_pd    = mk(30, 1'b0, 1'b0);
        wdma_done     = 1'b1;
        tick();
        wdma_done  = 1'b0;
        rdma2dp_pd = mk(31, 1'b0, 1'b0);
        tick();
        chk("t4_no_done_run", 128'(dp2reg_done), 128'(1'b0));
        rdma2dp_pd = mk(32, 1'b1, 1'b1);
        tick();
        rdma2dp_valid = 1'b0;
        chk("t4_pd_end", 128'(dp_pd), 128'(mk(32, 1'b1, 1'b1)));
        chk("t4_no_done_wait", 128'(dp2reg_done), 128'(1'b0));
        tick();
        chk("t4_done", 128'(dp2reg_done), 128'(1'b1));
        chk("t4_beat_num", 128'(dp2reg_beat_num), 128'(3));
        chk("t4_consumer", 128'(dp2reg_consumer), 128'(1'b0));
        tick();
        chk("t4_single_a", 128'(dp2reg_done), 128'(1'b0));
        tick();
        chk("t4_single_b", 128'(dp2reg_done), 128'(1'b0));

        // Back-to-back layers on group 0 then group 1
        reg2dp_op_en = 2'b00;
        tick();
        reg2dp_op_en = 2'b01;
        tick();
        tick();
        reg2dp_op_en  = 2'b11;
        rdma2dp_valid = 1'b1;
        rdma2dp_pd    = mk(40, 1'b0, 1'b0);
        tick();
        rdma2dp_pd = mk(41, 1'b1, 1'b1);
        tick();
        rdma2dp_valid = 1'b0;
        chk("t5_ready_wait", 128'(rdma2dp_ready), 128'(1'b0));
        wdma_done = 1'b1;
        tick();
        wdma_done = 1'b0;
        chk("t5_done0", 128'(dp2reg_done), 128'(1'b1));
        chk("t5_consumer1", 128'(dp2reg_consumer), 128'(1'b1));
        chk("t5_beat0", 128'(dp2reg_beat_num), 128'(2));
        tick();
        chk("t5_gap", 128'(dp2reg_done), 128'(1'b0));
        tick();
        chk("t5_ready_l1", 128'(rdma2dp_ready), 128'(1'b1));
        rdma2dp_valid = 1'b1;
        rdma2dp_pd    = mk(42, 1'b1, 1'b1);
        tick();
        rdma2dp_valid = 1'b0;
        wdma_done     = 1'b1;
        tick();
        wdma_done = 1'b0;
        chk("t5_done1", 128'(dp2reg_done), 128'(1'b1));
        chk("t5_consumer0", 128'(dp2reg_consumer), 128'(1'b0));
        chk("t5_beat1", 128'(dp2reg_beat_num), 128'(1));
        tick();

        // Reset mid-layer after two beats
        reg2dp_op_en = 2'b00;
        tick();
        reg2dp_op_en = 2'b01;
        tick();
        tick();
        rdma2dp_valid = 1'b1;
        rdma2dp_pd    = mk(50, 1'b0, 1'b0);
        tick();
        rdma2dp_pd = mk(51, 1'b0, 1'b0);
        tick();
        nvdla_core_rstn = 1'b0;
        #1;
        chk("t6_rst_pvld", 128'(dp_pvld), 128'(1'b0));
        chk("t6_rst_pd", 128'(dp_pd), 128'(0));
        chk("t6_rst_ready", 128'(rdma2dp_ready), 128'(1'b0));
        chk("t6_rst_consumer", 128'(dp2reg_consumer), 128'(1'b0));
        chk("t6_rst_beat", 128'(dp2reg_beat_num), 128'(0));
        rdma2dp_valid = 1'b0;
        reg2dp_op_en  = 2'b00;
        tick();
        chk("t6_rst_done", 128'(dp2reg_done), 128'(1'b0));
        tick();
        nvdla_core_rstn = 1'b1;
        tick();
        chk("t6_post_rst_done", 128'(dp2reg_done), 128'(1'b0));
        reg2dp_op_en = 2'b01;
        tick();
        tick();
        chk("t6_ready_restart", 128'(rdma2dp_ready), 128'(1'b1));
        for (int i = 0; i < 3; i++) begin
            rdma2dp_valid = 1'b1;
            rdma2dp_pd    = mk(60 + i, i == 2, i == 2);
            tick();
        end
        rdma2dp_valid = 1'b0;
        wdma_done     = 1'b1;
        tick();
        wdma_done = 1'b0;
        chk("t6_done", 128'(dp2reg_done), 128'(1'b1));
        chk("t6_beat_num", 128'(dp2reg_beat_num), 128'(3));
        chk("t6_consumer", 128'(dp2reg_consumer), 128'(1'b1));
        tick();
        chk("t6_done_pulse", 128'(dp2reg_done), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
